// File: rtl/matmul_host_seq.sv
// Host-side sequencer: streams A/B operands into a matmul engine, starts the
// multiply, then reads the C words back out one at a time.
module matmul_host_seq #(
   parameter int NUM_A_WORDS = 32,
   parameter int NUM_B_WORDS = 32,
   parameter int NUM_C_WORDS = 16,
   parameter int RD_LAT      = 4,
   parameter int WR_LAT      = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_start,
   output logic         busy,
   input  logic [255:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [255:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] data_pi,
   output logic [6:0]   addr_pi,
   output logic         we_a,
   output logic         we_b,
   output logic         we_c,
   output logic         enable_writing_to_mem,
   output logic         enable_reading_from_mem,
   output logic         start_mat_mul,
   input  logic         done_mat_mul,
   input  logic [255:0] data_from_out_mat
);

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, WR_DRAIN,
      COMPUTE, RD_ISSUE, RD_WAIT, RD_OUT
   } state_t;

   state_t state_q, state_d;
   logic [6:0] idx_q, idx_d;
   logic [6:0] rd_idx_q, rd_idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [255:0] out_data_q, out_data_d;
   logic [WR_LAT-1:0] wv_q, wv_d;
   logic [WR_LAT-1:0] wb_q, wb_d;
   logic [WR_LAT-1:0][255:0] wd_q, wd_d;
   logic run, loading, accept;

   assign run     = !reset;
   assign loading = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign accept  = loading && in_valid;

   always_comb begin
      wv_d = '0;
      wb_d = '0;
      wd_d = '0;
      wv_d[0] = accept;
      wb_d[0] = (state_q == LOAD_B);
      wd_d[0] = in_data;
      for (int i = 1; i < WR_LAT; i++) begin
         wv_d[i] = wv_q[i-1];
         wb_d[i] = wb_q[i-1];
         wd_d[i] = wd_q[i-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rd_idx_d   = rd_idx_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_start) begin
               state_d  = LOAD_A;
               idx_d    = '0;
               rd_idx_d = '0;
            end
         end
         LOAD_A: begin
            if (accept) begin
               if (idx_q == 7'(NUM_A_WORDS - 1)) begin
                  idx_d   = '0;
                  state_d = LOAD_B;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         LOAD_B: begin
            if (accept) begin
               if (idx_q == 7'(NUM_B_WORDS - 1)) begin
                  idx_d   = '0;
                  cnt_d   = 8'd1;
                  state_d = WR_DRAIN;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         WR_DRAIN: begin
            if (cnt_q >= 8'(WR_LAT)) state_d = COMPUTE;
            else cnt_d = cnt_q + 8'd1;
         end
         COMPUTE: begin
            if (done_mat_mul) state_d = RD_ISSUE;
         end
         RD_ISSUE: begin
            cnt_d   = 8'd1;
            state_d = RD_WAIT;
         end
         // Read data is taken in the last wait cycle: RD_LAT counts the issue cycle.
         RD_WAIT: begin
            if (cnt_q >= 8'(RD_LAT - 1)) begin
               out_data_d = data_from_out_mat;
               state_d    = RD_OUT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RD_OUT: begin
            if (out_ready) begin
               if (rd_idx_q == 7'(NUM_C_WORDS - 1)) begin
                  rd_idx_d = '0;
                  state_d  = IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + 7'd1;
                  state_d  = RD_ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rd_idx_q   <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         wv_q       <= '0;
         wb_q       <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rd_idx_q   <= rd_idx_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         wv_q       <= wv_d;
         wb_q       <= wb_d;
         wd_q       <= wd_d;
      end
   end

   always_comb begin
      busy      = run && (state_q != IDLE);
      in_ready  = run && loading;
      out_valid = run && (state_q == RD_OUT);
      out_data  = run ? out_data_q : '0;
      we_a      = run && wv_q[WR_LAT-1] && !wb_q[WR_LAT-1];
      we_b      = run && wv_q[WR_LAT-1] && wb_q[WR_LAT-1];
      data_pi   = (run && wv_q[WR_LAT-1]) ? wd_q[WR_LAT-1] : '0;
      addr_pi   = '0;
      if (run && loading) addr_pi = idx_q;
      else if (run && state_q == RD_ISSUE) addr_pi = rd_idx_q;
      enable_writing_to_mem = run && (loading || state_q == WR_DRAIN);
      enable_reading_from_mem = run &&
         (state_q == RD_ISSUE || state_q == RD_WAIT);
      start_mat_mul = run && (state_q == COMPUTE);
      we_c          = run && (state_q == COMPUTE);
   end

endmodule

// File: tb/tb_matmul_host_seq.sv
// Directed bench for matmul_host_seq with a small matmul memory model.
module tb_matmul_host_seq;
   localparam int NA = 32;
   localparam int NC = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cmd_start = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic done_mat_mul = 1'b0;
   logic [255:0] in_data = '0;
   logic busy, in_ready, out_valid;
   logic [255:0] out_data, data_pi, data_from_out_mat;
   logic [6:0] addr_pi;
   logic we_a, we_b, we_c, enable_writing_to_mem;
   logic enable_reading_from_mem, start_mat_mul;

   int errors = 0;
   int checks = 0;

   matmul_host_seq dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .busy(busy),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .data_pi(data_pi), .addr_pi(addr_pi), .we_a(we_a), .we_b(we_b),
      .we_c(we_c), .enable_writing_to_mem(enable_writing_to_mem),
      .enable_reading_from_mem(enable_reading_from_mem),
      .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
      .data_from_out_mat(data_from_out_mat)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] a_word(input int i);
      return {8{32'hA000_0000 | 32'(i)}};
   endfunction
   function automatic logic [255:0] b_word(input int i);
      return {8{32'hB000_0000 | 32'(i)}};
   endfunction
   function automatic logic [255:0] c_word(input int i);
      return {8{32'hC000_0000 | 32'(i)}};
   endfunction

   // Monitor and memory model
   int cyc_ctr = 0;
   int wr_bad = 0;
   int rd_bad = 0;
   int start_cnt = 0;
   int wec_cnt = 0;
   logic [1:0] acc_h = '0;
   logic [6:0] ah0 = '0;
   logic [6:0] ah1 = '0;
   logic [3:0] rdp = '0;
   logic [6:0] rda [4];
   logic en_prev = 1'b0;
   logic [263:0] wr_log [$];
   logic [255:0] out_log [$];
   int out_cyc [$];
   logic [6:0] iss_log [$];

   assign data_from_out_mat =
      rdp[3] ? c_word(int'(rda[3])) : {8{32'hDEAD_BEEF}};

   always @(negedge clk) begin
      cyc_ctr <= cyc_ctr + 1;
      if (reset) begin
         acc_h   <= '0;
         rdp     <= '0;
         en_prev <= 1'b0;
      end else begin
         if (we_a || we_b) begin
            if (!acc_h[1] || !enable_writing_to_mem || (we_a && we_b))
               wr_bad <= wr_bad + 1;
            wr_log.push_back({we_b, ah1, data_pi});
         end else if (acc_h[1]) begin
            wr_bad <= wr_bad + 1;
         end
         acc_h <= {acc_h[0], in_valid && in_ready};
         ah1 <= ah0;
         ah0 <= addr_pi;
         if (enable_reading_from_mem && !en_prev) begin
            if (rdp != '0 || out_valid) rd_bad <= rd_bad + 1;
            iss_log.push_back(addr_pi);
         end
         en_prev <= enable_reading_from_mem;
         rdp <= {rdp[2:0], enable_reading_from_mem && !en_prev};
         rda[3] <= rda[2];
         rda[2] <= rda[1];
         rda[1] <= rda[0];
         rda[0] <= addr_pi;
         if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            out_cyc.push_back(cyc_ctr);
         end
         if (start_mat_mul) start_cnt <= start_cnt + 1;
         if (we_c) wec_cnt <= wec_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [263:0] obs,
                      input logic [263:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 264'({busy, in_ready, out_valid, we_a, we_b,
          we_c, enable_writing_to_mem, enable_reading_from_mem,
          start_mat_mul, addr_pi}), 264'(0));
      chk({tag, "_dout"}, 264'(out_data), '0);
      chk({tag, "_dpi"}, 264'(data_pi), '0);
   endtask

   task automatic feed(input bit toggle_b, input int stop_at);
      int n = 0;
      int cyc = 0;
      while (n < stop_at && cyc < 400) begin
         in_valid = !(toggle_b && n >= NA && (cyc % 2 == 1));
         in_data = (n < NA) ? a_word(n) : b_word(n - NA);
         @(negedge clk);
         if (in_valid && in_ready) n++;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      chk("feed_count", 264'(n), 264'(stop_at));
   endtask

   task automatic wait_start();
      int k = 0;
      @(negedge clk);
      while (!start_mat_mul && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("start_seen", 264'(start_mat_mul), 264'(1));
   endtask

   task automatic wait_outs(input int base);
      int k = 0;
      while (out_log.size() - base < NC && k < 400) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic chk_wr(input int base, input string tag);
      int bad = 0;
      logic [255:0] d;
      chk({tag, "_wr_count"}, 264'(wr_log.size() - base), 264'(2 * NA));
      for (int j = 0; j < 2 * NA && base + j < wr_log.size(); j++) begin
         d = (j < NA) ? a_word(j) : b_word(j - NA);
         if (wr_log[base + j] !== {(j >= NA), 7'(j % NA), d}) bad++;
      end
      chk({tag, "_wr_seq"}, 264'(bad), 264'(0));
   endtask

   task automatic chk_rd(input int ob, input int ib, input string tag);
      int bad = 0;
      chk({tag, "_c_count"}, 264'(out_log.size() - ob), 264'(NC));
      chk({tag, "_iss_count"}, 264'(iss_log.size() - ib), 264'(NC));
      for (int i = 0; i < NC && ob + i < out_log.size(); i++)
         if (out_log[ob + i] !== c_word(i)) bad++;
      for (int i = 0; i < NC && ib + i < iss_log.size(); i++)
         if (iss_log[ib + i] !== 7'(i)) bad++;
      chk({tag, "_c_order"}, 264'(bad), 264'(0));
   endtask

   initial begin
      int s0, c0, ob0, ib0, wb0, bad, k, stall_bad;
      logic [255:0] hold;

      // Reset state
      repeat (2) step();
      @(negedge clk);
      chk_zero("reset_hold");
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("idle_busy", 264'({busy, in_ready}), 264'(0));
      step();

      // Job 1: streaming, done after 5 cycles, cmd_start during COMPUTE
      s0 = start_cnt; c0 = wec_cnt;
      ob0 = out_log.size(); ib0 = iss_log.size(); wb0 = wr_log.size();
      pulse_start();
      @(negedge clk);
      chk("load_a_first", 264'({busy, in_ready, enable_writing_to_mem,
          addr_pi}), 264'({3'b111, 7'd0}));
      step();
      feed(1'b0, 2 * NA);
      wait_start();
      chk("compute_enables", 264'({enable_writing_to_mem,
          enable_reading_from_mem}), 264'(0));
      step();
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
      step();
      step();
      done_mat_mul = 1'b1;
      step();
      done_mat_mul = 1'b0;
      @(negedge clk);
      chk("start_drop", 264'({start_mat_mul, we_c}), 264'(0));
      chk("start_len", 264'(start_cnt - s0), 264'(5));
      chk("we_c_len", 264'(wec_cnt - c0), 264'(5));
      wait_outs(ob0);
      chk_rd(ob0, ib0, "job1");
      bad = 0;
      for (int i = 1; i < NC && ob0 + i < out_cyc.size(); i++)
         if (out_cyc[ob0 + i] - out_cyc[ob0 + i - 1] != 5) bad++;
      chk("c_spacing", 264'(bad), 264'(0));
      chk_wr(wb0, "job1");
      repeat (10) step();
      @(negedge clk);
      chk("no_spurious_job", 264'(busy), 264'(0));
      chk("no_extra_writes", 264'(wr_log.size() - wb0), 264'(2 * NA));
      step();

      // Job 2: gaps in LOAD_B, done already high, back-pressure on word 3
      s0 = start_cnt;
      ob0 = out_log.size(); ib0 = iss_log.size(); wb0 = wr_log.size();
      done_mat_mul = 1'b1;
      out_ready = 1'b0;
      pulse_start();
      feed(1'b1, 2 * NA);
      wait_start();
      @(negedge clk);
      chk("forced_done_drop", 264'(start_mat_mul), 264'(0));
      chk("forced_done_len", 264'(start_cnt - s0), 264'(1));
      step();
      done_mat_mul = 1'b0;
      for (int w = 0; w < NC; w++) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!out_valid && k < 30);
         if (w == 3) begin
            hold = out_data;
            stall_bad = 0;
            repeat (10) begin
               @(negedge clk);
               if (!out_valid || out_data !== hold ||
                   enable_reading_from_mem || addr_pi != '0)
                  stall_bad++;
            end
            chk("stall_stable", 264'(stall_bad), 264'(0));
            chk("stall_word3", 264'(hold), 264'(c_word(3)));
         end
         step();
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      chk_rd(ob0, ib0, "job2");
      chk_wr(wb0, "job2");
      step();
      @(negedge clk);
      chk("job2_idle", 264'(busy), 264'(0));
      step();

      // Job 3: reset at B index 10, then a clean full job
      out_ready = 1'b1;
      pulse_start();
      feed(1'b0, NA + 10);
      @(negedge clk);
      chk("addr_b10", 264'({in_ready, addr_pi}), 264'({1'b1, 7'd10}));
      step();
      wb0 = wr_log.size();
      reset = 1'b1;
      in_valid = 1'b1;
      in_data = b_word(10);
      @(negedge clk);
      chk_zero("reset_mid");
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk_zero("post_reset");
      repeat (3) step();
      chk("no_write_after_reset", 264'(wr_log.size() - wb0), 264'(0));
      ob0 = out_log.size(); ib0 = iss_log.size(); wb0 = wr_log.size();
      pulse_start();
      feed(1'b0, 2 * NA);
      wait_start();
      step();
      done_mat_mul = 1'b1;
      step();
      done_mat_mul = 1'b0;
      wait_outs(ob0);
      chk_rd(ob0, ib0, "job3");
      chk_wr(wb0, "job3");

      chk("wr_pairing", 264'(wr_bad), 264'(0));
      chk("rd_outstanding", 264'(rd_bad), 264'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matmul_host_seq.md
MATMUL_HOST_SEQ -- requirements
Module: matmul_host_seq

Interface
REQ-001 SHALL have parameter NUM_A_WORDS, default 32, A words written at addresses 0..NUM_A_WORDS-1.
REQ-002 SHALL have parameter NUM_B_WORDS, default 32, B words written at addresses 0..NUM_B_WORDS-1.
REQ-003 SHALL have parameter NUM_C_WORDS, default 16, C words read back from addresses 0..NUM_C_WORDS-1.
REQ-004 SHALL have parameter RD_LAT, default 4, cycles from addr_pi driven to data_from_out_mat valid.
REQ-005 SHALL have parameter WR_LAT, default 2, cycles from addr_pi driven to the matching data_pi/we_* cycle.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port cmd_start, input, 1, one-cycle job request, honoured only in IDLE.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have in_data (input, 256), in_valid (input, 1), in_ready (output, 1): operand stream, A words first, then B words.
REQ-011 SHALL have out_data (output, 256), out_valid (output, 1), out_ready (input, 1): result stream of C words.
REQ-012 SHALL have matmul-side outputs data_pi (256), addr_pi (7), we_a, we_b, we_c, enable_writing_to_mem, enable_reading_from_mem, start_mat_mul (1 each).
REQ-013 SHALL have matmul-side inputs done_mat_mul (1) and data_from_out_mat (256).

Function
REQ-014 SHALL implement states IDLE, LOAD_A, LOAD_B, WR_DRAIN, COMPUTE, RD_ISSUE, RD_WAIT, RD_OUT.
REQ-015 IDLE -> LOAD_A on cmd_start; cmd_start in any other state SHALL be ignored.
REQ-016 in_ready SHALL be 1 only in LOAD_A/LOAD_B; a word is accepted when in_valid && in_ready.
REQ-017 An accepted word SHALL drive addr_pi = word index at cycle t, and data_pi = word plus we_a (LOAD_A) or we_b (LOAD_B) for exactly one cycle at t+WR_LAT.
REQ-018 enable_writing_to_mem SHALL be 1 from LOAD_A entry through the last delayed write cycle, and 0 otherwise.
REQ-019 Word index SHALL restart at 0 on entry to LOAD_B; LOAD_A -> LOAD_B after word NUM_A_WORDS-1; LOAD_B -> WR_DRAIN after word NUM_B_WORDS-1.
REQ-020 in_valid gaps SHALL stall the index without issuing a write; we_a/we_b SHALL never be 1 for an unaccepted word.
REQ-021 WR_DRAIN SHALL last WR_LAT cycles, completing pending delayed writes, then go to COMPUTE.
REQ-022 In COMPUTE, start_mat_mul and we_c SHALL be held 1 until done_mat_mul is sampled 1; both SHALL be 0 the next cycle, and state goes to RD_ISSUE.
REQ-023 RD_ISSUE SHALL drive addr_pi = read index with enable_reading_from_mem = 1 for one cycle, then go to RD_WAIT.
REQ-024 enable_reading_from_mem SHALL stay 1 from RD_ISSUE through RD_WAIT.
REQ-025 RD_WAIT SHALL count RD_LAT-1 cycles, capture data_from_out_mat into out_data, and go to RD_OUT.
REQ-026 In RD_OUT, out_valid SHALL be 1 and out_data stable until out_ready.
REQ-027 On an RD_OUT handshake, the read index SHALL increment and state goes to RD_ISSUE, or to IDLE after index NUM_C_WORDS-1.
REQ-028 Only one read SHALL be outstanding at a time.
REQ-029 Indices SHALL be 7 bits; parameter values above 128 are illegal, and no wrap-around occurs within a job.
REQ-030 If done_mat_mul is already 1 on COMPUTE entry, start_mat_mul SHALL still pulse for at least one cycle before exit.

Reset
REQ-031 reset SHALL force IDLE and clear indices, the write delay pipeline, and the RD_WAIT counter.
REQ-032 While reset is asserted, all outputs SHALL be 0 (busy, in_ready, out_valid, out_data, data_pi, addr_pi, all we/enable/start).
REQ-033 reset mid-job in any state SHALL abort with no further writes; the next cmd_start SHALL run a full job from A index 0.

Verification
REQ-034 Full job, in_valid always 1, out_ready always 1: 64 accepted words; we_a at addr 0..31, then we_b at addr 0..31, each 2 cycles after its addr_pi; start_mat_mul held until done; 16 C words out in address order, each 5 cycles apart.
REQ-035 in_valid toggled 1/0 during LOAD_B -> exactly 32 we_b pulses, with no duplicate or skipped addresses.
REQ-036 out_ready held 0 for 10 cycles on C word 3 -> out_data stable, no new addr_pi issued, and word 4 follows after release.
REQ-037 reset asserted in LOAD_B at index 10 -> next cycle all outputs 0 and state IDLE; cmd_start then restarts with A addr 0.
REQ-038 cmd_start pulsed during COMPUTE -> ignored; after a job ends, exactly one new job starts only on a new cmd_start.
REQ-039 done_mat_mul forced 1 at COMPUTE entry -> start_mat_mul 1 for exactly one cycle, and the read phase proceeds normally.
